// File: rtl/pad_reader_pkg.sv
// Shared types and helpers for the serial game-pad reader: FSM states,
// NES button bit positions and the microsecond-to-cycle conversion.
package pad_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    READ0,
    CLK_HI,
    CLK_LO,
    COMMIT,
    GAP
  } pad_state_t;

  // NES bit positions; LSB is the first bit the pad shifts out.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  function automatic int us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/pad_serial_reader_sync.sv
// Parametrised-width two-flop synchroniser for the asynchronous pad data lines.
module pad_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pad_serial_reader.sv
// Serial game-pad reader (NES/SNES) for NUM_PADS pads on a shared latch/clock.
// Optional macro PAD_DEBOUNCE_EN: commit a pad only when two consecutive raw frames agree.
module pad_serial_reader
  import pad_reader_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int LATCH_US = 12,
  parameter int HALF_US  = 6,
  parameter int GAP_US   = 0,
  parameter int NUM_BITS = 8,
  parameter int NUM_PADS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          data,
  output logic                         latch,
  output logic                         pad_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         frame_valid,
  output logic [NUM_PADS-1:0]          connected
);

  localparam int LATCH_CYC = us_to_cycles(CLK_HZ, LATCH_US);
  localparam int HALF_CYC  = us_to_cycles(CLK_HZ, HALF_US);
  localparam int GAP_CYC   = us_to_cycles(CLK_HZ, GAP_US);
  localparam int MAX_LH    = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int CNT_MAX   = (MAX_LH > GAP_CYC) ? MAX_LH : GAP_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int BIT_W     = $clog2(NUM_BITS);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  // The bit counter counts completed CLK_LO phases, so the final one is NUM_BITS-2.
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NUM_BITS - 2);

  pad_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BIT_W-1:0] bit_reg, bit_next;
  logic             sample;
  logic             commit;
  logic             latch_reg;
  logic             pad_clk_reg;
  logic             frame_valid_reg;
  logic [NUM_PADS-1:0] data_sync;

  pad_sync #(
    .WIDTH(NUM_PADS)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (data),
    .q    (data_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_reg         <= '0;
      latch_reg       <= 1'b0;
      pad_clk_reg     <= 1'b0;
      frame_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_reg         <= bit_next;
      latch_reg       <= (state_next == LATCH);
      pad_clk_reg     <= (state_next == CLK_HI);
      frame_valid_reg <= commit;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    bit_next   = bit_reg;
    sample     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (enable) state_next = LATCH;
      end
      LATCH: begin
        bit_next = '0;
        if (cnt_reg == LATCH_LAST) begin
          state_next = READ0;
          cnt_next   = '0;
        end
      end
      READ0: begin
        if (cnt_reg == HALF_LAST) begin
          sample     = 1'b1;
          state_next = CLK_HI;
          cnt_next   = '0;
        end
      end
      CLK_HI: begin
        if (cnt_reg == HALF_LAST) begin
          state_next = CLK_LO;
          cnt_next   = '0;
        end
      end
      CLK_LO: begin
        if (cnt_reg == HALF_LAST) begin
          sample   = 1'b1;
          cnt_next = '0;
          if (bit_reg == BIT_LAST) begin
            // The final bit is folded in on the same edge that enters COMMIT.
            commit     = 1'b1;
            state_next = COMMIT;
            bit_next   = '0;
          end else begin
            state_next = CLK_HI;
            bit_next   = bit_reg + BIT_W'(1);
          end
        end
      end
      COMMIT: begin
        cnt_next = '0;
        if (GAP_CYC > 0)  state_next = GAP;
        else if (enable)  state_next = LATCH;
        else              state_next = IDLE;
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = enable ? LATCH : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        bit_next   = '0;
      end
    endcase
  end

  assign latch       = latch_reg;
  assign pad_clk     = pad_clk_reg;
  assign frame_valid = frame_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [NUM_BITS-2:0] raw_reg;
      logic [NUM_BITS-1:0] raw_full;
      logic [NUM_BITS-1:0] btn_reg, btn_next;
      logic [NUM_BITS-1:0] press_reg, rel_reg;
      logic                pad_on;
      logic                accept;
      logic                conn_reg;

      assign raw_full = {data_sync[gi], raw_reg};
      assign pad_on   = |raw_full;
      // An all-zero frame means nothing is driving the line: report no buttons.
      assign btn_next = pad_on ? ~raw_full : '0;

`ifdef PAD_DEBOUNCE_EN
      logic [NUM_BITS-1:0] last_raw_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) last_raw_reg <= '0;
        else if (commit) last_raw_reg <= raw_full;
      end

      assign accept = (raw_full == last_raw_reg);
`else
      assign accept = 1'b1;
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          raw_reg   <= '0;
          btn_reg   <= '0;
          press_reg <= '0;
          rel_reg   <= '0;
          conn_reg  <= 1'b0;
        end else begin
          press_reg <= '0;
          rel_reg   <= '0;
          if (sample) raw_reg <= raw_full[NUM_BITS-1:1];
          if (commit) begin
            conn_reg <= pad_on;
            if (accept) begin
              btn_reg   <= btn_next;
              press_reg <= btn_next & ~btn_reg;
              rel_reg   <= ~btn_next & btn_reg;
            end
          end
        end
      end

      assign buttons[gi*NUM_BITS +: NUM_BITS]  = btn_reg;
      assign pressed[gi*NUM_BITS +: NUM_BITS]  = press_reg;
      assign released[gi*NUM_BITS +: NUM_BITS] = rel_reg;
      assign connected[gi]                     = conn_reg;
    end
  endgenerate

endmodule
